// File: rtl/cmd_sequencer.sv
// Command-script engine feeding RemoteComm: queues 16-bit commands, sends them one at a time,
// and checks each response byte against 8'hA5. Define SEQ_GAP_EN for an idle gap between commands.
module cmd_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TMO_W   = 24,
  parameter int TMO_CYC = 10000000,
  parameter int GAP_CYC = 150000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [15:0]              load_cmd,
  input  logic                     start,
  output logic [15:0]              cmd,
  output logic                     send_cmd,
  input  logic                     cmd_sent,
  input  logic                     resp_rdy,
  input  logic [7:0]               resp,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [$clog2(DEPTH):0]   n_done,
  output logic                     full,
  output logic                     empty
);

  // state      | meaning
  // IDLE       | waiting for load/start after reset
  // LOAD_CMD   | head of FIFO has just been popped into cmd
  // SEND       | send_cmd pulse to RemoteComm
  // WAIT_SENT  | waiting for cmd_sent, timeout armed
  // WAIT_RESP  | waiting for resp_rdy, timeout re-armed per response
  // GAP        | inter-command idle time (SEQ_GAP_EN only)
  // DONE       | all commands completed, done held
  // ERR        | run aborted, FIFO flushed, err held

  localparam int AW = $clog2(DEPTH);
  localparam logic [TMO_W-1:0] TMO_LD  = TMO_W'(TMO_CYC - 1);
  localparam logic [7:0]       RESP_OK = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_CMD  = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_SENT = 3'd3,
    ST_WAIT_RESP = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERR       = 3'd6
`ifdef SEQ_GAP_EN
    , ST_GAP     = 3'd7
`endif
  } state_t;

  state_t state, state_nxt;

  logic [15:0]      mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [TMO_W-1:0] tmo_cnt;
  logic [1:0]       resp_left;

  logic idle_like, load_ok, load_ovf, start_ok;
  logic pop, tmo_load, resp_load, resp_dec, cmd_ok, err_set, done_set;
  logic [1:0] err_code_nxt;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
  assign load_ok   = load && idle_like && !full;
  assign load_ovf  = load && idle_like && full;
  assign start_ok  = start && idle_like;
  assign busy      = !idle_like;
  assign send_cmd  = (state == ST_SEND);

`ifdef SEQ_GAP_EN
  localparam logic [TMO_W-1:0] GAP_LD = TMO_W'(GAP_CYC - 1);
  logic [TMO_W-1:0] gap_cnt;
  logic             gap_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              gap_cnt <= '0;
    else if (gap_load)                       gap_cnt <= GAP_LD;
    else if (state == ST_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    tmo_load     = 1'b0;
    resp_load    = 1'b0;
    resp_dec     = 1'b0;
    cmd_ok       = 1'b0;
    err_set      = 1'b0;
    err_code_nxt = 2'b00;
    done_set     = 1'b0;
`ifdef SEQ_GAP_EN
    gap_load     = 1'b0;
`endif
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          if (empty) begin
            state_nxt = ST_DONE;
            done_set  = 1'b1;
          end else begin
            state_nxt = ST_LOAD_CMD;
            pop       = 1'b1;
          end
        end
      end
      ST_LOAD_CMD: state_nxt = ST_SEND;
      ST_SEND: begin
        state_nxt = ST_WAIT_SENT;
        tmo_load  = 1'b1;
      end
      ST_WAIT_SENT: begin
        // cmd_sent beats a same-cycle timeout; resp_rdy here is ignored
        if (cmd_sent) begin
          state_nxt = ST_WAIT_RESP;
          tmo_load  = 1'b1;
          resp_load = 1'b1;
        end else if (tmo_cnt == '0) begin
          state_nxt    = ST_ERR;
          err_set      = 1'b1;
          err_code_nxt = 2'b01;
        end
      end
      ST_WAIT_RESP: begin
        if (resp_rdy) begin
          if (resp != RESP_OK) begin
            state_nxt    = ST_ERR;
            err_set      = 1'b1;
            err_code_nxt = 2'b10;
          end else if (resp_left == 2'd1) begin
            cmd_ok = 1'b1;
            if (empty) begin
              state_nxt = ST_DONE;
              done_set  = 1'b1;
            end else begin
`ifdef SEQ_GAP_EN
              state_nxt = ST_GAP;
              gap_load  = 1'b1;
`else
              state_nxt = ST_LOAD_CMD;
              pop       = 1'b1;
`endif
            end
          end else begin
            resp_dec = 1'b1;
            tmo_load = 1'b1;
          end
        end else if (tmo_cnt == '0) begin
          state_nxt    = ST_ERR;
          err_set      = 1'b1;
          err_code_nxt = 2'b01;
        end
      end
`ifdef SEQ_GAP_EN
      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = ST_LOAD_CMD;
          pop       = 1'b1;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load_ok) mem[wr_ptr[AW-1:0]] <= load_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd       <= 16'h0000;
      tmo_cnt   <= '0;
      resp_left <= 2'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
      n_done    <= '0;
    end else begin
      if (load_ok) wr_ptr <= wr_ptr + 1'b1;
      // cmd is updated on entry to LOAD_CMD so it is already stable the cycle before send_cmd
      if (pop) begin
        cmd    <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (err_set) rd_ptr <= wr_ptr;

      if (tmo_load)
        tmo_cnt <= TMO_LD;
      else if ((state == ST_WAIT_SENT || state == ST_WAIT_RESP) && tmo_cnt != '0)
        tmo_cnt <= tmo_cnt - 1'b1;

      if (resp_load)     resp_left <= (cmd[15:12] == 4'b0100) ? 2'd2 : 2'd1;
      else if (resp_dec) resp_left <= resp_left - 1'b1;

      if (start_ok) begin
        done     <= 1'b0;
        err      <= 1'b0;
        err_code <= 2'b00;
        n_done   <= '0;
      end
      if (cmd_ok)   n_done <= n_done + 1'b1;
      if (done_set) done   <= 1'b1;
      if (err_set) begin
        err      <= 1'b1;
        err_code <= err_code_nxt;
      end
      if (load_ovf) begin
        err      <= 1'b1;
        err_code <= 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: hand-written run sequences plus a table of FIFO load/start vectors.
// The GAP timing check is compiled only when SEQ_GAP_EN is defined.
module tb_cmd_sequencer;
  localparam int DEPTH   = 8;
  localparam int TMO_W   = 24;
  localparam int TMO_CYC = 1000;
  localparam int GAP_CYC = 100;
  localparam int NW      = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            load = 1'b0;
  logic [15:0]     load_cmd = 16'h0000;
  logic            start = 1'b0;
  logic            cmd_sent = 1'b0;
  logic            resp_rdy = 1'b0;
  logic [7:0]      resp = 8'h00;
  logic [15:0]     cmd;
  logic            send_cmd, busy, done, err, full, empty;
  logic [1:0]      err_code;
  logic [NW-1:0]   n_done;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] prev_cmd;

  typedef struct {
    logic        ld;
    logic [15:0] word;
    logic        st;
    logic        full;
    logic        empty;
    logic        err;
    logic        busy;
    logic        send;
    logic [1:0]  code;
  } vec_t;

  vec_t tbl [12];

  always #5 clk = ~clk;

  cmd_sequencer #(
    .DEPTH(DEPTH), .TMO_W(TMO_W), .TMO_CYC(TMO_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_cmd(load_cmd), .start(start),
    .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .n_done(n_done),
    .full(full), .empty(empty)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [15:0] w);
    load = 1'b1;
    load_cmd = w;
    tick();
    load = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_send(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      prev_cmd = cmd;
      tick();
      if (send_cmd === 1'b1) ok = 1'b1;
    end
  endtask

  // Called at the sample point of the send_cmd cycle.
  task automatic respond(input int dly, input int nresp, input logic [7:0] r);
    tick();
    chk("send_one_cycle", 32'(send_cmd), 0);
    repeat (dly - 1) tick();
    cmd_sent = 1'b1;
    tick();
    cmd_sent = 1'b0;
    for (int i = 0; i < nresp; i++) begin
      resp_rdy = 1'b1;
      resp = r;
      tick();
      resp_rdy = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int cnt;

    for (int i = 0; i < DEPTH; i++)
      tbl[i] = '{ld:1'b1, word:16'h2000 + 16'(i), st:1'b0, full:(i == DEPTH - 1),
                 empty:1'b0, err:1'b0, busy:1'b0, send:1'b0, code:2'b00};
    tbl[8]  = '{ld:1'b1, word:16'h2FFF, st:1'b0, full:1'b1, empty:1'b0, err:1'b1, busy:1'b0, send:1'b0, code:2'b11};
    tbl[9]  = '{ld:1'b0, word:16'h0000, st:1'b0, full:1'b1, empty:1'b0, err:1'b1, busy:1'b0, send:1'b0, code:2'b11};
    tbl[10] = '{ld:1'b0, word:16'h0000, st:1'b1, full:1'b0, empty:1'b0, err:1'b0, busy:1'b1, send:1'b0, code:2'b00};
    tbl[11] = '{ld:1'b1, word:16'h3333, st:1'b0, full:1'b0, empty:1'b0, err:1'b0, busy:1'b1, send:1'b1, code:2'b00};

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_send", 32'(send_cmd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_code", 32'(err_code), 0);
    chk("rst_ndone", 32'(n_done), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);

    // calibrate command, cmd_sent after 500 clocks
    load_word(16'h0000);
    pulse_start();
    chk("t1_busy", 32'(busy), 1);
    wait_send(20, ok);
    chk("t1_send_seen", 32'(ok), 1);
    chk("t1_cmd", 32'(cmd), 32'h0000);
    respond(500, 1, 8'hA5);
    chk("t1_done", 32'(done), 1);
    chk("t1_ndone", 32'(n_done), 1);
    chk("t1_err", 32'(err), 0);
    chk("t1_busy_end", 32'(busy), 0);

    // tour command needs two responses; resp_rdy alongside cmd_sent must not count
    load_word(16'h4022);
    pulse_start();
    chk("t2_done_cleared", 32'(done), 0);
    wait_send(20, ok);
    chk("t2_send_seen", 32'(ok), 1);
    chk("t2_cmd", 32'(cmd), 32'h4022);
    tick();
    chk("t2_send_one_cycle", 32'(send_cmd), 0);
    cmd_sent = 1'b1; resp_rdy = 1'b1; resp = 8'hA5;
    tick();
    cmd_sent = 1'b0; resp_rdy = 1'b0;
    tick();
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    chk("t2_done_after_first", 32'(done), 0);
    chk("t2_busy_after_first", 32'(busy), 1);
    chk("t2_ndone_after_first", 32'(n_done), 0);
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    chk("t2_done_after_second", 32'(done), 1);
    chk("t2_ndone", 32'(n_done), 1);

    // bad second response aborts the script and flushes the queue
    load_word(16'h2001);
    load_word(16'h2BF1);
    load_word(16'h27F1);
    pulse_start();
    wait_send(20, ok);
    chk("t3_send1_seen", 32'(ok), 1);
    chk("t3_cmd1", 32'(cmd), 32'h2001);
    respond(5, 1, 8'hA5);
    wait_send(20, ok);
    chk("t3_send2_seen", 32'(ok), 1);
    chk("t3_cmd2", 32'(cmd), 32'h2BF1);
    chk("t3_cmd2_stable", 32'(prev_cmd), 32'h2BF1);
    respond(5, 1, 8'h5A);
    chk("t3_err", 32'(err), 1);
    chk("t3_code", 32'(err_code), 2);
    chk("t3_ndone", 32'(n_done), 1);
    chk("t3_empty", 32'(empty), 1);
    chk("t3_busy", 32'(busy), 0);
    cnt = 0;
    repeat (30) begin
      tick();
      if (send_cmd === 1'b1) cnt++;
    end
    chk("t3_no_third_send", 32'(cnt), 0);

    // cmd_sent never arrives: timeout exactly TMO_CYC clocks after WAIT_SENT entry
    load_word(16'h2001);
    pulse_start();
    chk("t4_err_cleared", 32'(err), 0);
    chk("t4_code_cleared", 32'(err_code), 0);
    wait_send(20, ok);
    chk("t4_send_seen", 32'(ok), 1);
    repeat (TMO_CYC) tick();
    chk("t4_no_err_early", 32'(err), 0);
    tick();
    chk("t4_err", 32'(err), 1);
    chk("t4_code", 32'(err_code), 1);
    chk("t4_busy", 32'(busy), 0);

    // start with empty FIFO
    pulse_start();
    chk("t5_empty_done", 32'(done), 1);
    chk("t5_empty_busy", 32'(busy), 0);
    chk("t5_empty_err", 32'(err), 0);

    // asynchronous reset in the middle of a send
    load_word(16'h2001);
    load_word(16'h2002);
    pulse_start();
    wait_send(20, ok);
    chk("t6_send_seen", 32'(ok), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_send", 32'(send_cmd), 0);
    chk("t6_rst_cmd", 32'(cmd), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_empty", 32'(empty), 1);
    tick();
    rst_n = 1'b1;
    tick();

    // FIFO fill, overflow, start, load-while-busy
    for (int v = 0; v < 12; v++) begin
      load = tbl[v].ld;
      load_cmd = tbl[v].word;
      start = tbl[v].st;
      tick();
      load = 1'b0;
      start = 1'b0;
      chk($sformatf("vec%0d", v), 32'({full, empty, err, busy, send_cmd, err_code}),
          32'({tbl[v].full, tbl[v].empty, tbl[v].err, tbl[v].busy, tbl[v].send, tbl[v].code}));
    end
    for (int c = 0; c < DEPTH; c++) begin
      if (c > 0) begin
        wait_send(20, ok);
        chk("t7_send_seen", 32'(ok), 1);
      end
      chk($sformatf("t7_cmd%0d", c), 32'(cmd), 32'(16'h2000 + 16'(c)));
      tick();
      cmd_sent = 1'b1;
      tick();
      cmd_sent = 1'b0;
      resp_rdy = 1'b1;
      resp = 8'hA5;
      tick();
      resp_rdy = 1'b0;
    end
    chk("t7_ndone", 32'(n_done), DEPTH);
    chk("t7_done", 32'(done), 1);
    chk("t7_empty", 32'(empty), 1);
    chk("t7_err", 32'(err), 0);

`ifdef SEQ_GAP_EN
    load_word(16'h2001);
    load_word(16'h2002);
    pulse_start();
    wait_send(20, ok);
    chk("gap_send1_seen", 32'(ok), 1);
    respond(3, 1, 8'hA5);
    cnt = 0;
    ok = 1'b0;
    while (!ok && cnt < 300) begin
      tick();
      cnt++;
      if (send_cmd === 1'b1) ok = 1'b1;
    end
    chk("gap_cycles", 32'(cnt), GAP_CYC + 1);
    respond(3, 1, 8'hA5);
    chk("gap_done", 32'(done), 1);
    chk("gap_ndone", 32'(n_done), 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
- Synthesizable command-script engine directly upstream of RemoteComm; replaces hand-written bench stimulus for the Knight's Tour system.
- Holds a small FIFO of 16-bit commands. On start, issues each command to RemoteComm as a cmd/send_cmd pulse pair.
- Waits for cmd_sent, then for the expected number of resp_rdy pulses, checking each response against 8'hA5 under a per-phase timeout.
- Reports done or error with a code; used by system benches and FPGA bring-up.

Parameters:
- DEPTH, 8, command FIFO entries; power of 2, minimum 2.
- TMO_W, 24, width of the timeout counter.
- TMO_CYC, 10000000, clocks allowed per wait phase (cmd_sent or each resp_rdy); must fit in TMO_W.
- GAP_CYC, 150000, inter-command idle clocks; used only with SEQ_GAP_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  write load_cmd into FIFO this cycle
- load_cmd  in  16  command word to enqueue
- start  in  1  begin executing queued commands
- cmd  out  16  command word to RemoteComm
- send_cmd  out  1  one-cycle send request to RemoteComm
- cmd_sent  in  1  RemoteComm finished transmitting cmd
- resp_rdy  in  1  RemoteComm received a response byte
- resp  in  8  response byte, valid with resp_rdy
- busy  out  1  high from start acceptance until DONE/ERR
- done  out  1  sticky: all commands completed OK
- err  out  1  sticky error flag
- err_code  out  2  01 = timeout, 10 = bad response, 11 = overflow; 00 = none
- n_done  out  log2(DEPTH)+1  count of commands completed OK this run
- full  out  1  FIFO full
- empty  out  1  FIFO empty

Behaviour:
- Reset (async, rst_n low): FIFO empty, state IDLE, cmd=16'h0000, send_cmd=0, busy=0, done=0, err=0, err_code=00, n_done=0.
- Load: accepted only in IDLE, DONE or ERR, and only when not full.
  - Load while full: word dropped, err=1, err_code=11; state unchanged.
  - Load while busy: ignored silently.
- Start: accepted in IDLE/DONE/ERR only; clears done, err, err_code and n_done.
  - Start with an empty FIFO: done=1 on the next clock, busy stays 0.
- States and transitions:
  - IDLE
  - LOAD_CMD: pop head into cmd.
  - SEND: send_cmd=1 for exactly one cycle. cmd is stable from the cycle before send_cmd until a new command is loaded.
  - WAIT_SENT: wait for cmd_sent.
  - WAIT_RESP: wait for resp_rdy.
  - GAP: only with SEQ_GAP_EN.
  - DONE
  - ERR
- Expected response count: 2 when cmd[15:12]==4'b0100 (tour: move ack plus tour-complete); 1 for all other opcodes, including calibrate 4'b0000 and move 4'b0010.
- Response check: each resp sampled on the resp_rdy cycle.
  - resp != 8'hA5 -> ERR, err_code=10.
  - The last expected good response increments n_done and goes to GAP (if enabled) or LOAD_CMD. If the FIFO is empty, go to DONE instead.
- Timeout: counter cleared on entry to WAIT_SENT and on each WAIT_RESP entry or accepted response.
  - Counter reaching TMO_CYC -> ERR, err_code=01.
  - Event and timeout in the same cycle: the event wins.
- resp_rdy pulses outside WAIT_RESP are ignored. A cmd_sent and resp_rdy coincidence in WAIT_SENT counts only cmd_sent.
- Entering ERR flushes the FIFO and holds busy=0 and err=1 until the next start or reset.
- DONE: done=1, busy=0.
- Reset mid-run: everything returns to reset values immediately; a partially sent command is abandoned.
- FIFO: circular, read/write pointers one bit wider than the index. full/empty are derived from the pointers. No simultaneous load and pop, because load is blocked while busy.

Optional Feature:
- SEQ_GAP_EN defined: after each completed command, wait GAP_CYC clocks in GAP before LOAD_CMD. A GAP counter of TMO_W bits is not subject to timeout. No gap after the final command.
- SEQ_GAP_EN undefined: GAP state and counter are absent; LOAD_CMD follows immediately.

Test Plan:
- Reset, load 16'h0000, start; model asserts cmd_sent after 500 clocks, then resp 8'hA5 -> send_cmd one pulse with cmd=16'h0000, then done=1, n_done=1, err=0.
- Load 16'h4022, start; model returns A5 twice -> exactly two responses consumed, done=1 only after the second.
- Load 16'h2001, 16'h2BF1, 16'h27F1; second response is 8'h5A -> err=1, err_code=10, n_done=1, third command never sent (no third send_cmd), empty=1.
- Load 16'h2001 with TMO_CYC=1000; model never asserts cmd_sent -> err_code=01 exactly 1000 clocks after WAIT_SENT entry.
- Load DEPTH+1 words -> full=1 after DEPTH; extra word sets err_code=11. Then start runs exactly DEPTH commands, giving n_done=DEPTH.
- With SEQ_GAP_EN and GAP_CYC=100, two commands -> second send_cmd occurs at least 100 clocks after the first response.
